replace_unit: RTL
=================

REPLACE_UNIT -- requirements
Module: replace_unit

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; no other clocks or asynchronous inputs.
REQ-002 Parameter DEPTH, default 256, SHALL set the number of sets (>=1).
REQ-003 Parameter WAY_NUM, default 4, SHALL set the ways per set (power of two, >=2).
REQ-004 Parameter READ_PORT, default 1, SHALL set the number of hit-update ports (>=1).
REQ-005 Parameter MODE, default 0, SHALL select the policy: 0 = tree-PLRU, 1 = LFSR random.
REQ-006 Derived WAY_WIDTH = clog2(WAY_NUM) and ADDR_WIDTH = (DEPTH<=1 ? 1 : clog2(DEPTH)) SHALL size the way and index ports.
REQ-007 Port clk  in  1  clock.
REQ-008 Port rst  in  1  synchronous active-high reset.
REQ-009 Port hit_en  in  READ_PORT  per-port access-update valid.
REQ-010 Port hit_way  in  READ_PORT x WAY_WIDTH  accessed way per port.
REQ-011 Port hit_index  in  READ_PORT x ADDR_WIDTH  accessed set per port.
REQ-012 Port miss_index  in  ADDR_WIDTH  set being queried for a victim.
REQ-013 Port miss_en  in  1  commits the presented miss_way as allocated.
REQ-014 Port flush  in  1  clears all replacement state.
REQ-015 Port miss_way  out  WAY_WIDTH  victim way for miss_index.

Function
REQ-016 MODE 0 SHALL hold WAY_NUM-1 tree bits per set, with heap numbering: root = node 0, children of node n = 2n+1 and 2n+2.
REQ-017 Tree bit value 0 SHALL point the victim search to the lower-way half and value 1 to the upper half.
REQ-018 In MODE 0, miss_way SHALL be decoded combinationally (zero latency) from the registered bits of miss_index.
REQ-019 An access to way w SHALL set every node on w's path to point away from w, effective at the next clock edge.
REQ-020 Each hit_en[p] SHALL apply an access update for hit_way[p] at hit_index[p].
REQ-021 miss_en SHALL apply an access update for the current miss_way at miss_index.
REQ-022 Updates to different sets in the same cycle SHALL all take effect independently.
REQ-023 Updates to the same set SHALL apply in order port 0..READ_PORT-1, then miss; a later update SHALL overwrite earlier ones on shared path nodes only.
REQ-024 miss_way SHALL reflect only registered state; same-cycle hits SHALL NOT be forwarded into it.
REQ-025 MODE 1 SHALL use a 16-bit Fibonacci LFSR (taps 16,14,13,11) and SHALL present miss_way = lfsr[WAY_WIDTH-1:0].
REQ-026 In MODE 1 the LFSR SHALL advance only on cycles with miss_en=1, and hit updates SHALL have no effect.
REQ-027 flush SHALL zero all tree bits and reload the LFSR seed at the next edge, taking priority over same-cycle updates.
REQ-028 Indices >= DEPTH (non-power-of-two DEPTH) SHALL produce no state change, and miss_way SHALL be 0 for such a miss_index.

Reset
REQ-029 While rst=1, all tree bits SHALL be cleared to 0 and the LFSR SHALL load 16'h0001 at each edge; rst SHALL override flush and all updates.
REQ-030 After reset, miss_way SHALL read 0 in MODE 0 and 1 in MODE 1 (WAY_NUM>=4).
REQ-031 Reset asserted mid-sequence SHALL discard any same-cycle update.

Structure
REQ-032 The MODE encodings, the LFSR seed and the tap constant SHALL live in the shared defines package.
REQ-033 Path decode/update SHALL be one sub-module, plru_tree_update (inputs: tree bits, way; outputs: new bits, victim), instantiated once per update port plus once for the miss port.

Verification
REQ-034 MODE 0, WAY_NUM=4: reset, then miss_en=1 on set 5 for 5 cycles -> miss_way sequence 0,2,1,3,0.
REQ-035 MODE 0: hit way 0 on set 3, then next cycle query set 3 -> miss_way=2; set 4 still returns 0.
REQ-036 READ_PORT=2: port0 hit way 0 and port1 hit way 1 on set 7 in the same cycle -> next miss_way=2 (root=1 from port1, node1 last written by port1 = 0 -> node2=0 -> way 2).
REQ-037 Same cycle: hit set 9 way 3 plus flush -> next cycle every set returns miss_way=0.
REQ-038 MODE 1, WAY_NUM=4: reset, then 3 miss_en pulses -> miss_way sequence 1, then the low two bits of the LFSR stepped from 0x0001, matching a reference model; no change on hit-only cycles.
REQ-039 Assert rst during a burst of miss_en on set 2 -> the cycle after rst deasserts, miss_way=0.

Source files
------------

// File: rtl/replace_unit_pkg.sv
// Shared replacement-policy constants: policy encodings and LFSR definition.
package replace_unit_pkg;

  localparam int MODE_PLRU = 0;
  localparam int MODE_LFSR = 1;

  localparam logic [15:0] LFSR_SEED = 16'h0001;
  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One LFSR step: shift left, feed back the parity of the tapped bits
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/replace_unit_tree.sv
// Tree-PLRU path logic for one set: victim decode and access update.
module plru_tree_update #(
  parameter int WAY_NUM = 4,
  localparam int WW = $clog2(WAY_NUM),
  localparam int TW = WAY_NUM - 1
) (
  input  logic [TW-1:0] tree,
  input  logic [WW-1:0] way,
  output logic [TW-1:0] new_tree,
  output logic [WW-1:0] victim
);

  // Walk from the root following the bits; each bit picks the half holding the victim
  always_comb begin
    int   n;
    logic b;
    n      = 0;
    b      = 1'b0;
    victim = '0;
    for (int l = 0; l < WW; l++) begin
      b      = |(tree & (TW'(1) << n));
      victim = (victim << 1) | WW'(b);
      n      = 2 * n + 1 + int'(b);
    end
  end

  // Rewrite every node on way's path to point at the opposite half
  always_comb begin
    int   node;
    logic b;
    node     = 0;
    b        = 1'b0;
    new_tree = tree;
    for (int l = 0; l < WW; l++) begin
      node     = (1 << l) - 1 + (int'(way) >> (WW - l));
      b        = ((int'(way) >> (WW - 1 - l)) & 1) == 0;
      new_tree = (new_tree & ~(TW'(1) << node)) | (TW'(b) << node);
    end
  end

endmodule

// File: rtl/replace_unit.sv
// Victim-way selector: per-set tree-PLRU or a shared LFSR, chosen by MODE.
module replace_unit
  import replace_unit_pkg::*;
#(
  parameter int DEPTH     = 256,
  parameter int WAY_NUM   = 4,
  parameter int READ_PORT = 1,
  parameter int MODE      = 0,
  localparam int WAY_WIDTH  = $clog2(WAY_NUM),
  localparam int ADDR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [READ_PORT-1:0]                  hit_en,
  input  logic [READ_PORT-1:0][WAY_WIDTH-1:0]   hit_way,
  input  logic [READ_PORT-1:0][ADDR_WIDTH-1:0]  hit_index,
  input  logic [ADDR_WIDTH-1:0]                 miss_index,
  input  logic                                  miss_en,
  input  logic                                  flush,
  output logic [WAY_WIDTH-1:0]                  miss_way
);

  localparam int TW = WAY_NUM - 1;
  localparam int NP = READ_PORT + 1;   // hit ports plus the miss port (highest slot)

  logic miss_ok;
  assign miss_ok = int'(miss_index) < DEPTH;

  generate
    if (MODE == MODE_PLRU) begin : g_plru

      logic [DEPTH-1:0][TW-1:0]      tree_q, tree_d;
      logic [NP-1:0][ADDR_WIDTH-1:0] u_idx;
      logic [NP-1:0][WAY_WIDTH-1:0]  u_way, u_vic;
      logic [NP-1:0][TW-1:0]         u_base, u_new;
      logic [NP-1:0]                 u_en;

      // Bits on w's path; only these nodes are touched by an access to w
      function automatic logic [TW-1:0] path_mask(input logic [WAY_WIDTH-1:0] w);
        logic [TW-1:0] m;
        m = '0;
        for (int l = 0; l < WAY_WIDTH; l++)
          m |= TW'(1) << ((1 << l) - 1 + (int'(w) >> (WAY_WIDTH - l)));
        return m;
      endfunction

      assign u_idx    = {miss_index, hit_index};
      assign u_way    = {miss_way, hit_way};
      // Out-of-range miss index sees an all-zero tree, so its victim decodes to 0
      assign miss_way = u_vic[NP-1];

      // Gather registered bits per port; out-of-range indices neither read nor write
      always_comb begin
        u_en   = '0;
        u_base = '0;
        for (int p = 0; p < NP; p++) begin
          if (int'(u_idx[p]) < DEPTH) begin
            u_base[p] = tree_q[u_idx[p]];
            u_en[p]   = (p == NP - 1) ? miss_en : hit_en[p];
          end
        end
      end

      for (genvar p = 0; p < NP; p++) begin : g_port
        plru_tree_update #(.WAY_NUM(WAY_NUM)) u_tree (
          .tree     (u_base[p]),
          .way      (u_way[p]),
          .new_tree (u_new[p]),
          .victim   (u_vic[p])
        );
      end

      // Apply updates in port order; a later port overrides only its own path nodes
      always_comb begin
        tree_d = tree_q;
        for (int p = 0; p < NP; p++)
          if (u_en[p])
            tree_d[u_idx[p]] = (tree_d[u_idx[p]] & ~path_mask(u_way[p])) |
                               (u_new[p] & path_mask(u_way[p]));
      end

      // Tree state register; reset and flush both clear every set
      always_ff @(posedge clk) begin
        if (rst || flush) tree_q <= '0;
        else              tree_q <= tree_d;
      end

    end else begin : g_lfsr

      logic [15:0] lfsr_q;

      assign miss_way = miss_ok ? lfsr_q[WAY_WIDTH-1:0] : '0;

      // Random victim source; steps only when a valid miss commits
      always_ff @(posedge clk) begin
        if (rst || flush)          lfsr_q <= LFSR_SEED;
        else if (miss_en && miss_ok) lfsr_q <= lfsr_step(lfsr_q);
      end

    end
  endgenerate

endmodule
